// File: rtl/mux3_arbiter_if.sv
// Handshake bundle between the three requesters and the shared-port arbiter.
// master: requester side (drives requests and the resource ack).
// slave : arbiter side (drives grants, mux select, strobe and timeout pulse).
interface mux3_arbiter_if;
  logic [2:0] I_req;
  logic       I_ack;
  logic [2:0] O_gnt;
  logic [1:0] O_sel;
  logic       O_busy;
  logic       O_timeout;

  modport master (
    output I_req,
    output I_ack,
    input  O_gnt,
    input  O_sel,
    input  O_busy,
    input  O_timeout
  );

  modport slave (
    input  I_req,
    input  I_ack,
    output O_gnt,
    output O_sel,
    output O_busy,
    output O_timeout
  );
endinterface

// File: rtl/mux3_arbiter.sv
// Round-robin arbiter for one shared 32-bit port used by CPU fetch (0),
// load/store (1) and debug/DMA (2). A grant is held until the resource acks;
// on ack the next requester in round-robin order is granted without a bubble.
// Optional macro MUX3_ARB_TIMEOUT_EN: force-release a grant that stays
// un-acked for TIMEOUT cycles and pulse O_timeout for one cycle.
// All outputs are registered; no input reaches an output combinationally.
module mux3_arbiter #(
  parameter int unsigned TIMEOUT = 32'd255,
  parameter int unsigned CNT_W   = 32'd8
) (
  input  logic          I_clk,
  input  logic          I_rst,
  mux3_arbiter_if.slave bus
);

  typedef enum logic [0:0] {
    ST_IDLE = 1'b0,
    ST_BUSY = 1'b1
  } state_t;

  // Mux select value meaning "nobody granted"; the data mux outputs zero.
  localparam logic [1:0] SEL_IDLE = 2'b11;

  state_t     state_r, state_nxt_s;
  logic [1:0] ptr_r,   ptr_nxt_s;     // last-served requester (lowest priority)
  logic [2:0] gnt_r,   gnt_nxt_s;
  logic [1:0] sel_r,   sel_nxt_s;     // doubles as the granted index while busy
  logic       busy_r,  busy_nxt_s;
  logic [1:0] win_s;

  // Highest-priority active requester seen from pointer p: p+1, p+2, then p.
  // Only called with at least one request bit set.
  function automatic logic [1:0] pick_f(input logic [1:0] p, input logic [2:0] req);
    logic [1:0] first;
    logic [1:0] second;
    logic [1:0] third;
    case (p)
      2'd0: begin first = 2'd1; second = 2'd2; third = 2'd0; end
      2'd1: begin first = 2'd2; second = 2'd0; third = 2'd1; end
      default: begin first = 2'd0; second = 2'd1; third = 2'd2; end
    endcase
    if (req[first]) begin
      pick_f = first;
    end else if (req[second]) begin
      pick_f = second;
    end else begin
      pick_f = third;
    end
  endfunction

  // One-hot grant vector for a requester index.
  function automatic logic [2:0] onehot_f(input logic [1:0] idx);
    case (idx)
      2'd0:    onehot_f = 3'b001;
      2'd1:    onehot_f = 3'b010;
      2'd2:    onehot_f = 3'b100;
      default: onehot_f = 3'b000;
    endcase
  endfunction

`ifdef MUX3_ARB_TIMEOUT_EN
  localparam logic [CNT_W-1:0] TMO_C = CNT_W'(TIMEOUT);
  logic [CNT_W-1:0] cnt_r, cnt_nxt_s;
  logic             timeout_r, timeout_nxt_s;
`else
  logic unused_cfg_s;
  assign unused_cfg_s = ^{TIMEOUT[0], CNT_W[0]};
`endif

  // Next-state, pointer and registered-output computation.
  always_comb begin
    state_nxt_s = state_r;
    ptr_nxt_s   = ptr_r;
    gnt_nxt_s   = gnt_r;
    sel_nxt_s   = sel_r;
    busy_nxt_s  = busy_r;
    win_s       = 2'd0;
`ifdef MUX3_ARB_TIMEOUT_EN
    timeout_nxt_s = 1'b0;
    cnt_nxt_s     = cnt_r;
`endif
    case (state_r)
      ST_IDLE: begin
        if (bus.I_req != 3'b000) begin
          win_s       = pick_f(ptr_r, bus.I_req);
          state_nxt_s = ST_BUSY;
          gnt_nxt_s   = onehot_f(win_s);
          sel_nxt_s   = win_s;
          busy_nxt_s  = 1'b1;
`ifdef MUX3_ARB_TIMEOUT_EN
          cnt_nxt_s   = {CNT_W{1'b0}};
`endif
        end else begin
          state_nxt_s = ST_IDLE;
        end
      end
      ST_BUSY: begin
        if (bus.I_ack) begin
          // The just-finished requester becomes lowest priority for the handoff.
          ptr_nxt_s = sel_r;
          if (bus.I_req != 3'b000) begin
            win_s       = pick_f(sel_r, bus.I_req);
            state_nxt_s = ST_BUSY;
            gnt_nxt_s   = onehot_f(win_s);
            sel_nxt_s   = win_s;
            busy_nxt_s  = 1'b1;
`ifdef MUX3_ARB_TIMEOUT_EN
            cnt_nxt_s   = {CNT_W{1'b0}};
`endif
          end else begin
            state_nxt_s = ST_IDLE;
            gnt_nxt_s   = 3'b000;
            sel_nxt_s   = SEL_IDLE;
            busy_nxt_s  = 1'b0;
          end
        end
`ifdef MUX3_ARB_TIMEOUT_EN
        else if (cnt_r == TMO_C) begin
          // Stuck grant: drop it, demote the stuck requester, flag the event.
          ptr_nxt_s     = sel_r;
          state_nxt_s   = ST_IDLE;
          gnt_nxt_s     = 3'b000;
          sel_nxt_s     = SEL_IDLE;
          busy_nxt_s    = 1'b0;
          timeout_nxt_s = 1'b1;
          cnt_nxt_s     = {CNT_W{1'b0}};
        end
`endif
        else begin
          state_nxt_s = ST_BUSY;
`ifdef MUX3_ARB_TIMEOUT_EN
          cnt_nxt_s   = cnt_r + {{(CNT_W-1){1'b0}}, 1'b1};
`endif
        end
      end
      default: begin
        state_nxt_s = ST_IDLE;
        gnt_nxt_s   = 3'b000;
        sel_nxt_s   = SEL_IDLE;
        busy_nxt_s  = 1'b0;
      end
    endcase
  end

  // State, pointer and output registers with asynchronous reset.
  always_ff @(posedge I_clk or posedge I_rst) begin
    if (I_rst) begin
      state_r <= ST_IDLE;
      ptr_r   <= 2'd2;
      gnt_r   <= 3'b000;
      sel_r   <= SEL_IDLE;
      busy_r  <= 1'b0;
    end else begin
      state_r <= state_nxt_s;
      ptr_r   <= ptr_nxt_s;
      gnt_r   <= gnt_nxt_s;
      sel_r   <= sel_nxt_s;
      busy_r  <= busy_nxt_s;
    end
  end

`ifdef MUX3_ARB_TIMEOUT_EN
  // Un-acked cycle counter and one-cycle forced-release pulse.
  always_ff @(posedge I_clk or posedge I_rst) begin
    if (I_rst) begin
      cnt_r     <= {CNT_W{1'b0}};
      timeout_r <= 1'b0;
    end else begin
      cnt_r     <= cnt_nxt_s;
      timeout_r <= timeout_nxt_s;
    end
  end

  assign bus.O_timeout = timeout_r;
`else
  assign bus.O_timeout = 1'b0;
`endif

  assign bus.O_gnt  = gnt_r;
  assign bus.O_sel  = sel_r;
  assign bus.O_busy = busy_r;

endmodule

// File: tb/tb_mux3_arbiter.sv
// Bench for mux3_arbiter: directed scenarios with literal expectations plus
// randomized requests/acks compared every cycle against a behavioural model.
module tb_mux3_arbiter;

`ifdef MUX3_ARB_TIMEOUT_EN
  localparam int TB_TMO = 4;
  localparam int HOLD_N = 4;
`else
  localparam int TB_TMO = 255;
  localparam int HOLD_N = 5;
`endif

  logic clk;
  logic rst;
  mux3_arbiter_if bus();

  mux3_arbiter #(.TIMEOUT(TB_TMO), .CNT_W(8)) dut (
    .I_clk (clk),
    .I_rst (rst),
    .bus   (bus.slave)
  );

  int pass_cnt  = 0;
  int total_cnt = 0;

  // Behavioural model: who owns the port, who was served last, how long.
  bit m_busy  = 1'b0;
  int m_owner = 0;
  int m_ptr   = 2;
  int m_cnt   = 0;
  bit m_to    = 1'b0;

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total_cnt++;
    if (act === exp) pass_cnt++;
    else $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
  endtask

  function automatic int pick(input int p, input logic [2:0] r);
    for (int k = 1; k <= 3; k++) begin
      int c;
      c = (p + k) % 3;
      if (r[c]) return c;
    end
    return -1;
  endfunction

  task automatic model_step();
    if (rst) begin
      m_busy = 1'b0; m_ptr = 2; m_cnt = 0; m_to = 1'b0; m_owner = 0;
    end else begin
      m_to = 1'b0;
      if (!m_busy) begin
        if (bus.I_req != 3'b000) begin
          m_owner = pick(m_ptr, bus.I_req); m_busy = 1'b1; m_cnt = 0;
        end
      end else if (bus.I_ack) begin
        m_ptr = m_owner;
        if (bus.I_req != 3'b000) begin
          m_owner = pick(m_ptr, bus.I_req); m_cnt = 0;
        end else begin
          m_busy = 1'b0;
        end
      end
`ifdef MUX3_ARB_TIMEOUT_EN
      else if (m_cnt == TB_TMO) begin
        m_ptr = m_owner; m_busy = 1'b0; m_to = 1'b1; m_cnt = 0;
      end
`endif
      else begin
        m_cnt++;
      end
    end
  endtask

  // Model advances on every clock edge and on reset assertion.
  initial forever begin
    @(posedge clk or posedge rst);
    model_step();
  end

  // Per-cycle compare of DUT outputs against the model, mid-cycle.
  initial forever begin
    @(negedge clk);
    chk("cyc_gnt",  {29'd0, bus.O_gnt},  m_busy ? (32'd1 << m_owner) : 32'd0);
    chk("cyc_sel",  {30'd0, bus.O_sel},  m_busy ? m_owner : 32'd3);
    chk("cyc_busy", {31'd0, bus.O_busy}, {31'd0, m_busy});
    chk("cyc_to",   {31'd0, bus.O_timeout}, {31'd0, m_to});
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic lit(input string name, input logic [2:0] g, input logic [1:0] s, input logic b);
    chk({name, "_gnt"},  {29'd0, bus.O_gnt},  {29'd0, g});
    chk({name, "_sel"},  {30'd0, bus.O_sel},  {30'd0, s});
    chk({name, "_busy"}, {31'd0, bus.O_busy}, {31'd0, b});
  endtask

  initial begin
    int seq [4] = '{1, 2, 0, 1};
    rst = 1'b1;
    bus.I_req = 3'b000;
    bus.I_ack = 1'b0;
    repeat (3) tick();
    lit("reset", 3'b000, 2'b11, 1'b0);
    chk("reset_to", {31'd0, bus.O_timeout}, 32'd0);
    rst = 1'b0;

    // All three requesting: 0,1,2,0,1 with no idle bubble between grants.
    bus.I_req = 3'b111;
    tick();
    lit("rr_first", 3'b001, 2'b00, 1'b1);
    foreach (seq[i]) begin
      bus.I_ack = 1'b1;
      tick();
      lit("rr_next", 3'(1 << seq[i]), 2'(seq[i]), 1'b1);
      bus.I_ack = 1'b0;
      tick();
      lit("rr_hold", 3'(1 << seq[i]), 2'(seq[i]), 1'b1);
    end
    bus.I_req = 3'b000;
    bus.I_ack = 1'b1;
    tick();
    lit("rr_idle", 3'b000, 2'b11, 1'b0);
    bus.I_ack = 1'b0;

    // Sole requester 1: re-granted while still requesting, idle once dropped.
    bus.I_req = 3'b010;
    tick();
    lit("solo_gnt", 3'b010, 2'b01, 1'b1);
    bus.I_ack = 1'b1;
    tick();
    lit("solo_regnt", 3'b010, 2'b01, 1'b1);
    bus.I_req = 3'b000;
    tick();
    lit("solo_idle", 3'b000, 2'b11, 1'b0);
    bus.I_ack = 1'b0;

    // Requester 2 drops its request; grant is held until the ack.
    bus.I_req = 3'b100;
    tick();
    lit("drop_gnt", 3'b100, 2'b10, 1'b1);
    bus.I_req = 3'b000;
    for (int i = 0; i < HOLD_N; i++) begin
      tick();
      lit("drop_hold", 3'b100, 2'b10, 1'b1);
    end
    bus.I_ack = 1'b1;
    tick();
    lit("drop_rel", 3'b000, 2'b11, 1'b0);
    bus.I_ack = 1'b0;

    // Asynchronous reset in the middle of a grant to requester 1.
    bus.I_req = 3'b111;
    tick();
    lit("mid_g0", 3'b001, 2'b00, 1'b1);
    bus.I_ack = 1'b1;
    tick();
    lit("mid_g1", 3'b010, 2'b01, 1'b1);
    bus.I_ack = 1'b0;
    #2 rst = 1'b1;
    #1 lit("async_rst", 3'b000, 2'b11, 1'b0);
    tick();
    rst = 1'b0;
    tick();
    lit("post_rst", 3'b001, 2'b00, 1'b1);

`ifdef MUX3_ARB_TIMEOUT_EN
    // Requester 1 never acked: forced release and a single-cycle pulse.
    bus.I_req = 3'b010;
    bus.I_ack = 1'b1;
    tick();
    lit("to_gnt", 3'b010, 2'b01, 1'b1);
    bus.I_ack = 1'b0;
    bus.I_req = 3'b011;
    for (int i = 0; i < TB_TMO; i++) begin
      tick();
      lit("to_wait", 3'b010, 2'b01, 1'b1);
      chk("to_wait_pulse", {31'd0, bus.O_timeout}, 32'd0);
    end
    tick();
    lit("to_rel", 3'b000, 2'b11, 1'b0);
    chk("to_pulse", {31'd0, bus.O_timeout}, 32'd1);
    tick();
    lit("to_regnt", 3'b001, 2'b00, 1'b1);
    chk("to_pulse_end", {31'd0, bus.O_timeout}, 32'd0);
    // Ack arrives in the very cycle the counter hits the limit.
    for (int i = 0; i < TB_TMO; i++) tick();
    bus.I_ack = 1'b1;
    tick();
    lit("to_ackwins", 3'b010, 2'b01, 1'b1);
    chk("to_ackwins_pulse", {31'd0, bus.O_timeout}, 32'd0);
    bus.I_ack = 1'b0;
`endif

    // Randomized traffic with occasional asynchronous reset pulses.
    for (int i = 0; i < 3000; i++) begin
      bus.I_req = 3'($urandom_range(0, 7));
      bus.I_ack = ($urandom_range(0, 2) == 0);
      if ($urandom_range(0, 199) == 0) begin
        #2 rst = 1'b1;
        #1 rst = 1'b0;
      end
      tick();
    end

    @(negedge clk);
    #1;
    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish, passed %0d of %0d", pass_cnt, total_cnt);
    $fatal(1);
  end

endmodule
